// File: rtl/sme_mem_pkg.sv
// Shared definitions for the sensor-manager memory arbiter: state encoding,
// mux select values and counter widths.
package sme_mem_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_GRANT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_GRANT  = ST_GRANT
  } arbState_e;

  localparam logic SEL_SME  = 1'b0;
  localparam logic SEL_HOST = 1'b1;

  localparam int TURN_W = 4;
  localparam int WAIT_W = 10;

endpackage

// File: rtl/sme_wait_counter.sv
// Saturating port-0 wait counter with a sticky starvation flag.
// Clear beats every other update, including a same-cycle flag set.
module sme_wait_counter
  import sme_mem_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic              ClockIn,
  input  logic              ResetIn_n,
  input  logic              CountEnable,
  input  logic              Restart,
  input  logic              Clear,
  output logic [WAIT_W-1:0] Count,
  output logic              Starve
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] countNext;
  logic              starveNext;

  always_comb begin
    countNext  = Count;
    starveNext = Starve;
    if (Clear) begin
      countNext  = '0;
      starveNext = 1'b0;
    end else begin
      if (Restart) begin
        countNext = '0;
      end else if (CountEnable && (Count < MAX_CNT)) begin
        countNext = Count + 1'b1;
      end
      if (countNext == MAX_CNT) begin
        starveNext = 1'b1;
      end
    end
  end

  always_ff @(posedge ClockIn or negedge ResetIn_n) begin
    if (!ResetIn_n) begin
      Count  <= '0;
      Starve <= 1'b0;
    end else begin
      Count  <= countNext;
      Starve <= starveNext;
    end
  end

endmodule

// File: rtl/sme_memory_arbiter.sv
// Two-master arbiter for the shared sensor-manager memory. Drives the mux
// Select and gates memory enables off while Select changes and settles.
module sme_memory_arbiter
  import sme_mem_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int PRIORITY0   = 1,
  parameter int MAX_WAIT    = 64
) (
  input  logic       ClockIn,
  input  logic       ResetIn_n,
  input  logic       Req0,
  input  logic       Req1,
  input  logic       ClearStarve,
  output logic       Grant0,
  output logic       Grant1,
  output logic       Select,
  output logic       AccessEnable,
  output logic       Busy,
  output logic       Starve0,
  output logic [1:0] DebugState
);

  // Handshake: a master raises Req and holds it until it has seen its Grant;
  // dropping Req while granted releases the memory at the next edge.

  arbState_e         state, stateNext;
  logic              selNext, grant0Next, grant1Next, accessNext;
  logic              lastOwner, lastOwnerNext;
  logic [TURN_W-1:0] cnt, cntNext;
  logic              winner, ownerReq;
  logic [WAIT_W-1:0] waitCount;

  always_comb begin
    if (Req0 && Req1) begin
      winner = (PRIORITY0 != 0) ? SEL_SME : ~lastOwner;
    end else begin
      winner = Req1 ? SEL_HOST : SEL_SME;
    end
    // The current owner (or pending winner during SETTLE) is always Select.
    ownerReq = (Select == SEL_HOST) ? Req1 : Req0;

    stateNext     = state;
    selNext       = Select;
    grant0Next    = Grant0;
    grant1Next    = Grant1;
    accessNext    = AccessEnable;
    cntNext       = cnt;
    lastOwnerNext = lastOwner;

    case (state)
      S_IDLE: begin
        if (Req0 || Req1) begin
          if (winner == Select) begin
            stateNext  = S_GRANT;
            grant0Next = (winner == SEL_SME);
            grant1Next = (winner == SEL_HOST);
            accessNext = 1'b1;
          end else begin
            stateNext = S_SETTLE;
            selNext   = winner;
            cntNext   = TURN_W'(TURN_CYCLES - 1);
          end
        end
      end
      S_SETTLE: begin
        if (!ownerReq) begin
          stateNext = S_IDLE;
        end else if (cnt == '0) begin
          stateNext  = S_GRANT;
          grant0Next = (Select == SEL_SME);
          grant1Next = (Select == SEL_HOST);
          accessNext = 1'b1;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      S_GRANT: begin
        if (!ownerReq) begin
          stateNext     = S_IDLE;
          grant0Next    = 1'b0;
          grant1Next    = 1'b0;
          accessNext    = 1'b0;
          lastOwnerNext = Select;
        end
      end
      default: begin
        stateNext  = S_IDLE;
        grant0Next = 1'b0;
        grant1Next = 1'b0;
        accessNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ClockIn or negedge ResetIn_n) begin
    if (!ResetIn_n) begin
      state        <= S_IDLE;
      Select       <= SEL_SME;
      Grant0       <= 1'b0;
      Grant1       <= 1'b0;
      AccessEnable <= 1'b0;
      Busy         <= 1'b0;
      cnt          <= '0;
      lastOwner    <= SEL_HOST;
    end else begin
      state        <= stateNext;
      Select       <= selNext;
      Grant0       <= grant0Next;
      Grant1       <= grant1Next;
      AccessEnable <= accessNext;
      Busy         <= (stateNext != S_IDLE);
      cnt          <= cntNext;
      lastOwner    <= lastOwnerNext;
    end
  end

  assign DebugState = state;

  sme_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_waitCounter (
    .ClockIn    (ClockIn),
    .ResetIn_n  (ResetIn_n),
    .CountEnable(Req0 & ~Grant0),
    .Restart    (grant0Next & ~Grant0),
    .Clear      (ClearStarve),
    .Count      (waitCount),
    .Starve     (Starve0)
  );

endmodule

// File: tb/tb_sme_memory_arbiter.sv
// Directed bench for sme_memory_arbiter: fixed-priority instance plus a
// round-robin instance sharing clock and reset.
module tb_sme_memory_arbiter;

  logic       ClockIn;
  logic       ResetIn_n;
  logic       Req0, Req1, ClearStarve;
  logic       Grant0, Grant1, Select, AccessEnable, Busy, Starve0;
  logic [1:0] DebugState;

  logic       reqB0, reqB1, clearB;
  logic       grantB0, grantB1, selectB, accessB, busyB, starveB;
  logic [1:0] stateB;

  int testCount = 0;
  int failCount = 0;

  sme_memory_arbiter #(.TURN_CYCLES(2), .PRIORITY0(1), .MAX_WAIT(64)) dut (
    .ClockIn(ClockIn), .ResetIn_n(ResetIn_n), .Req0(Req0), .Req1(Req1),
    .ClearStarve(ClearStarve), .Grant0(Grant0), .Grant1(Grant1),
    .Select(Select), .AccessEnable(AccessEnable), .Busy(Busy),
    .Starve0(Starve0), .DebugState(DebugState)
  );

  sme_memory_arbiter #(.TURN_CYCLES(2), .PRIORITY0(0), .MAX_WAIT(64)) dutRr (
    .ClockIn(ClockIn), .ResetIn_n(ResetIn_n), .Req0(reqB0), .Req1(reqB1),
    .ClearStarve(clearB), .Grant0(grantB0), .Grant1(grantB1),
    .Select(selectB), .AccessEnable(accessB), .Busy(busyB),
    .Starve0(starveB), .DebugState(stateB)
  );

  initial begin
    ClockIn = 1'b0;
    forever #5 ClockIn = ~ClockIn;
  end

  task automatic tick();
    @(posedge ClockIn);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ResetIn_n = 1'b1;
    Req0 = 1'b0; Req1 = 1'b0; ClearStarve = 1'b0;
    reqB0 = 1'b0; reqB1 = 1'b0; clearB = 1'b0;
    #1 ResetIn_n = 1'b0;
    #2;
    chk("rst_state", DebugState, 2'd0);
    chk("rst_select", 2'(Select), 2'd0);
    chk("rst_grant0", 2'(Grant0), 2'd0);
    chk("rst_grant1", 2'(Grant1), 2'd0);
    chk("rst_access", 2'(AccessEnable), 2'd0);
    chk("rst_busy", 2'(Busy), 2'd0);
    chk("rst_starve", 2'(Starve0), 2'd0);
    tick(); tick();
    ResetIn_n = 1'b1;
    tick();

    // port 0 from idle with Select already 0: one-edge latency
    Req0 = 1'b1;
    tick();
    chk("p0_grant0", 2'(Grant0), 2'd1);
    chk("p0_access", 2'(AccessEnable), 2'd1);
    chk("p0_select", 2'(Select), 2'd0);
    chk("p0_busy", 2'(Busy), 2'd1);
    chk("p0_state", DebugState, 2'd2);
    tick(); tick();
    chk("p0_hold", 2'(Grant0), 2'd1);
    Req0 = 1'b0;
    tick();
    chk("p0_release", 2'(Grant0), 2'd0);
    chk("p0_rel_access", 2'(AccessEnable), 2'd0);
    chk("p0_rel_busy", 2'(Busy), 2'd0);

    // port 1 from idle: Select flips, two settle cycles, grant after edge 3
    Req1 = 1'b1;
    tick();
    chk("p1_e1_select", 2'(Select), 2'd1);
    chk("p1_e1_access", 2'(AccessEnable), 2'd0);
    chk("p1_e1_state", DebugState, 2'd1);
    chk("p1_e1_busy", 2'(Busy), 2'd1);
    tick();
    chk("p1_e2_access", 2'(AccessEnable), 2'd0);
    chk("p1_e2_grant1", 2'(Grant1), 2'd0);
    tick();
    chk("p1_e3_grant1", 2'(Grant1), 2'd1);
    chk("p1_e3_access", 2'(AccessEnable), 2'd1);

    // starvation: port 0 waits behind a long host grant
    Req0 = 1'b1;
    repeat (63) tick();
    chk("starve_63", 2'(Starve0), 2'd0);
    tick();
    chk("starve_64", 2'(Starve0), 2'd1);
    repeat (6) tick();
    chk("no_preempt_g1", 2'(Grant1), 2'd1);
    chk("no_preempt_g0", 2'(Grant0), 2'd0);
    Req1 = 1'b0;
    tick();
    chk("h_rel_grant1", 2'(Grant1), 2'd0);
    chk("h_rel_state", DebugState, 2'd0);
    chk("h_rel_select", 2'(Select), 2'd1);
    tick();
    chk("sw0_select", 2'(Select), 2'd0);
    chk("sw0_state", DebugState, 2'd1);
    tick(); tick();
    chk("sw0_grant0", 2'(Grant0), 2'd1);
    chk("starve_sticky", 2'(Starve0), 2'd1);
    ClearStarve = 1'b1;
    tick();
    ClearStarve = 1'b0;
    chk("starve_clear", 2'(Starve0), 2'd0);
    Req0 = 1'b0;
    tick();
    chk("sw0_release", 2'(Grant0), 2'd0);

    // simultaneous requests, fixed priority
    Req0 = 1'b1; Req1 = 1'b1;
    tick();
    chk("pri_grant0", 2'(Grant0), 2'd1);
    chk("pri_grant1", 2'(Grant1), 2'd0);
    Req0 = 1'b0;
    tick();
    chk("pri_idle", DebugState, 2'd0);
    tick();
    chk("pri_settle", DebugState, 2'd1);
    chk("pri_select", 2'(Select), 2'd1);
    tick();
    chk("pri_settle2_g1", 2'(Grant1), 2'd0);
    tick();
    chk("pri_grant1_late", 2'(Grant1), 2'd1);
    Req1 = 1'b0;
    tick();

    // port 0 back on Select 0, then host aborts in its first settle cycle
    Req0 = 1'b1;
    repeat (3) tick();
    chk("ab_pre_grant0", 2'(Grant0), 2'd1);
    Req0 = 1'b0;
    tick();
    Req1 = 1'b1;
    tick();
    chk("ab_settle", DebugState, 2'd1);
    Req1 = 1'b0;
    tick();
    chk("ab_state", DebugState, 2'd0);
    chk("ab_select", 2'(Select), 2'd1);
    chk("ab_access", 2'(AccessEnable), 2'd0);
    chk("ab_grant1", 2'(Grant1), 2'd0);
    tick();
    chk("ab_still_idle", 2'(Grant1), 2'd0);

    // round-robin instance: 0, 1, 0
    reqB0 = 1'b1; reqB1 = 1'b1;
    tick();
    chk("rr1_grant0", 2'(grantB0), 2'd1);
    chk("rr1_grant1", 2'(grantB1), 2'd0);
    reqB0 = 1'b0;
    tick();
    chk("rr1_idle", stateB, 2'd0);
    reqB0 = 1'b1;
    tick();
    chk("rr2_settle", stateB, 2'd1);
    tick(); tick();
    chk("rr2_grant1", 2'(grantB1), 2'd1);
    chk("rr2_grant0", 2'(grantB0), 2'd0);
    reqB1 = 1'b0;
    tick();
    reqB1 = 1'b1;
    tick(); tick(); tick();
    chk("rr3_grant0", 2'(grantB0), 2'd1);
    chk("rr3_grant1", 2'(grantB1), 2'd0);
    reqB0 = 1'b0; reqB1 = 1'b0;
    tick();

    // asynchronous reset in the middle of a host grant
    Req1 = 1'b1;
    tick();
    chk("ar_pre_grant1", 2'(Grant1), 2'd1);
    #3 ResetIn_n = 1'b0;
    #1;
    chk("ar_grant1", 2'(Grant1), 2'd0);
    chk("ar_access", 2'(AccessEnable), 2'd0);
    chk("ar_select", 2'(Select), 2'd0);
    chk("ar_state", DebugState, 2'd0);
    Req1 = 1'b0;
    tick();
    ResetIn_n = 1'b1;
    tick();
    chk("ar_after_idle", 2'(Busy), 2'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/sme_memory_arbiter.md
Name: sme_memory_arbiter

Overview:
- Arbitrates the shared sensor-manager memory between two masters: port 0 is the sensor manager engine, port 1 is the host/Wishbone side.
- Drives the Select input of the downstream memory mux directly upstream of it.
- Guarantees a glitch-free handover: the memory read and write enables are gated off while Select changes and for a programmable settle time afterwards.
- Provides a request/grant handshake to each master and a sticky starvation flag for the sensor manager.

Parameters:
- TURN_CYCLES, 2, settle cycles after a Select change before a grant is issued (min 1, max 15).
- PRIORITY0, 1, 1 = port 0 always wins simultaneous requests; 0 = round-robin.
- MAX_WAIT, 64, port-0 wait cycles that set Starve0 (min 1, max 1023).

Ports:
- ClockIn  in  1  single system clock; all state on rising edge.
- ResetIn_n  in  1  asynchronous, active-low reset.
- Req0  in  1  level request from sensor manager; held high for the whole access.
- Req1  in  1  level request from host; held high for the whole access.
- Grant0  out  1  port 0 owns memory.
- Grant1  out  1  port 1 owns memory.
- Select  out  1  to mux Select; 0 = port 0 path, 1 = port 1 path.
- AccessEnable  out  1  ANDed with the mux ReadEnableOut/WriteEnableOut; 0 blocks memory access.
- Busy  out  1  state != IDLE.
- Starve0  out  1  sticky port-0 starvation flag.
- ClearStarve  in  1  synchronous clear of Starve0 and the wait counter.

Behaviour:
- Interface: one clock (ClockIn); reset is asynchronous and active-low (ResetIn_n).
- All outputs are registered.
- Reset, async, valid at any time including mid-access:
  - state = IDLE; Select = 0; Grant0 = Grant1 = 0; AccessEnable = 0; Busy = 0; Starve0 = 0.
  - wait counter = 0; LastOwner = 1, so port 0 wins the first round-robin.
- States:
  - IDLE: no grant. AccessEnable = 0.
  - SETTLE: Select just changed; countdown in progress. AccessEnable = 0.
  - GRANT: exactly one Grant high. AccessEnable = 1.
- IDLE, winner selection at each edge:
  - Only one Req high: that port wins.
  - Both high, PRIORITY0 = 1: port 0 wins.
  - Both high, PRIORITY0 = 0: the port != LastOwner wins.
- IDLE, transition once a winner exists:
  - winner == Select: go to GRANT. Grant and AccessEnable are high after that edge (latency 1 edge).
  - winner != Select: Select <= winner, cnt <= TURN_CYCLES-1, go to SETTLE.
- SETTLE:
  - Winner's Req still high: decrement cnt each edge; at the edge where cnt == 0, go to GRANT. Total request-to-grant latency = 1 + TURN_CYCLES edges.
  - Winner's Req low at any SETTLE edge: abort to IDLE. Select holds its new value; no grant is issued.
  - A late request from the other port during SETTLE does not change the winner.
- GRANT:
  - Owner's Req low at an edge: Grant and AccessEnable drop after that edge, LastOwner <= owner, go to IDLE.
  - Minimum gap between successive grants: 1 IDLE cycle.
  - A request from the other port never preempts the owner.
  - Req held for a single cycle still yields a 1-cycle grant: Req must stay high until Grant is seen.
- Select changes only on the IDLE -> SETTLE edge, never while AccessEnable = 1.
- Grant0 and Grant1 are never high simultaneously.
- Starvation:
  - Wait counter (10 bits) increments each cycle with Req0 = 1 and Grant0 = 0; it saturates at MAX_WAIT.
  - It resets to 0 on the edge Grant0 rises.
  - Starve0 sets when the counter reaches MAX_WAIT and stays set until ClearStarve or reset.
  - ClearStarve in the same cycle as the set condition: clear wins.

Decomposition:
- Shared package sme_mem_pkg holds:
  - state encoding localparams ST_IDLE = 2'd0, ST_SETTLE = 2'd1, ST_GRANT = 2'd2;
  - SEL_SME = 1'b0, SEL_HOST = 1'b1;
  - counter widths.
- One sub-module, sme_wait_counter: saturating counter with sticky flag, parameterised by MAX_WAIT.
- The FSM stays in the top level.

Test Plan:
- Reset, then Req0 = 1 at cycle 2 -> Grant0 = 1 and AccessEnable = 1 after edge 3; Select stays 0. Req0 = 0 at cycle 6 -> Grant0 = 0 after edge 7.
- Req1 = 1 from idle with Select = 0, TURN_CYCLES = 2 -> Select = 1 after edge 1, AccessEnable = 0 for 2 cycles, Grant1 = 1 after edge 3.
- Req0 = Req1 = 1 from idle:
  - PRIORITY0 = 1: Grant0 first; Grant1 follows 1 IDLE + 2 SETTLE cycles after Req0 drops.
  - PRIORITY0 = 0: grants alternate 0, 1, 0 over repeated requests.
- Req1 drops during SETTLE cycle 1 -> no Grant1, state IDLE, Select = 1, AccessEnable stays 0.
- Host holds Grant1 for 70 cycles while Req0 = 1, MAX_WAIT = 64 -> Starve0 = 1 after wait count 64; stays set after Grant0; ClearStarve pulse -> 0.
- ResetIn_n asserted mid-GRANT, asynchronously between edges -> Grant1, AccessEnable and Select = 0 immediately, without waiting for a clock edge.
